// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared state, height and line constants for the gravity-flip game
package game_pkg;

  typedef enum logic [1:0] {
    ST_REST,
    ST_FLIP,
    ST_MOVE,
    ST_DEAD
  } state_t;

  localparam int H_W = 9;

  localparam logic [H_W-1:0] REST_UP_LO   = 9'd120;
  localparam logic [H_W-1:0] REST_DN_LO   = 9'd180;
  localparam logic [H_W-1:0] REST_UP_HI   = 9'd240;
  localparam logic [H_W-1:0] REST_DN_HI   = 9'd300;
  localparam logic [H_W-1:0] LIMIT_LO     = 9'd60;
  localparam logic [H_W-1:0] LIMIT_HI     = 9'd360;
  localparam logic [H_W-1:0] START_HEIGHT = 9'd120;

  localparam int LINE_LO  = 0;
  localparam int LINE_MID = 1;
  localparam int LINE_HI  = 2;

  // Cycles FLIP waits for the gravity block to acknowledge a request.
  localparam int FLIP_WAIT = 2;

  function automatic logic is_supported(input logic [H_W-1:0] h, input logic d,
                                        input logic [2:0] l);
    if (!d)
      return (h == REST_UP_LO && l[LINE_LO]) || (h == REST_UP_HI && l[LINE_MID]);
    else
      return (h == REST_DN_HI && l[LINE_HI]) || (h == REST_DN_LO && l[LINE_MID]);
  endfunction

  function automatic logic at_limit(input logic [H_W-1:0] h, input logic d);
    return d ? (h <= LIMIT_LO) : (h >= LIMIT_HI);
  endfunction

endpackage

// File: rtl/rise_edge.sv
// rtl/rise_edge.sv - rising-edge detector against a registered copy of the input
module rise_edge (
  input  logic clk,
  input  logic reset,
  input  logic sig,
  output logic rise
);

  logic sig_q;

  always_ff @(posedge clk) begin
    if (reset) sig_q <= 1'b0;
    else       sig_q <= sig;
  end

  assign rise = sig & ~sig_q;

endmodule

// File: rtl/player_vertical_ctrl.sv
// rtl/player_vertical_ctrl.sv - player height sequencer: rest, flip handshake, move, death
module player_vertical_ctrl
  import game_pkg::*;
#(
  parameter int               STEP    = 4,
  parameter logic [H_W-1:0]   START_H = START_HEIGHT
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           tick,
  input  logic           btn,
  input  logic           restart,
  input  logic           dir,
  input  logic [2:0]     lines,
  output logic [H_W-1:0] height,
  output logic           switch_req,
  output logic           grounded,
  output logic           is_dead
);

  state_t         state;
  logic           dir_q;
  logic [1:0]     flip_cnt;
  logic           btn_rise;
  logic [H_W-1:0] stepped_h;
  logic           pre_limit;
  logic           supported;
  logic           new_supported;
  logic           new_limit;
  logic           move_tick;

  rise_edge u_btn_edge (
    .clk   (clk),
    .reset (reset),
    .sig   (btn),
    .rise  (btn_rise)
  );

  // Limit is checked on the current height first so the step can never wrap.
  always_comb begin
    stepped_h     = dir ? (height - H_W'(STEP)) : (height + H_W'(STEP));
    pre_limit     = at_limit(height, dir);
    supported     = is_supported(height, dir, lines);
    new_supported = is_supported(stepped_h, dir, lines);
    new_limit     = at_limit(stepped_h, dir);
  end

  assign move_tick = (state == ST_MOVE) && tick && !pre_limit;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_REST;
      switch_req <= 1'b0;
      grounded   <= 1'b1;
      is_dead    <= 1'b0;
      dir_q      <= 1'b0;
      flip_cnt   <= '0;
    end else begin
      switch_req <= 1'b0;
      unique case (state)
        ST_REST: begin
          if (btn_rise && supported) begin
            switch_req <= 1'b1;
            dir_q      <= dir;
            flip_cnt   <= '0;
            grounded   <= 1'b0;
            state      <= ST_FLIP;
          end else if (tick && !supported) begin
            grounded <= 1'b0;
            state    <= ST_MOVE;
          end
        end
        ST_FLIP: begin
          if (dir != dir_q) begin
            state <= ST_MOVE;
          end else if (flip_cnt == 2'(FLIP_WAIT - 1)) begin
            grounded <= 1'b1;
            state    <= ST_REST;
          end else begin
            flip_cnt <= flip_cnt + 2'd1;
          end
        end
        ST_MOVE: begin
          if (tick) begin
            if (pre_limit || new_limit) begin
              is_dead <= 1'b1;
              state   <= ST_DEAD;
            end else if (new_supported) begin
              grounded <= 1'b1;
              state    <= ST_REST;
            end
          end
        end
        ST_DEAD: begin
          if (restart) begin
            is_dead  <= 1'b0;
            grounded <= 1'b1;
            state    <= ST_REST;
          end
        end
        default: state <= ST_REST;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      height <= START_H;
    else if (state == ST_DEAD && restart)
      height <= START_H;
    else if (move_tick)
      height <= stepped_h;
  end

endmodule

// File: tb/tb_player_vertical_ctrl.sv
// tb/tb_player_vertical_ctrl.sv - self-checking bench with a behavioural player model
module tb_player_vertical_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick = 1'b0;
  logic       btn = 1'b0;
  logic       restart = 1'b0;
  logic       dir = 1'b0;
  logic [2:0] lines = 3'b001;
  logic [8:0] height;
  logic       switch_req;
  logic       grounded;
  logic       is_dead;

  player_vertical_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .tick       (tick),
    .btn        (btn),
    .restart    (restart),
    .dir        (dir),
    .lines      (lines),
    .height     (height),
    .switch_req (switch_req),
    .grounded   (grounded),
    .is_dead    (is_dead)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;
  bit chk_en = 0;
  bit accept = 1;
  int sw_seen = 0;

  // Behavioural model: what the player is doing, described by plain integers.
  localparam int P_REST = 10, P_FLIP = 11, P_MOVE = 12, P_DEAD = 13;
  int m_h = 120;
  int m_phase = P_REST;
  bit m_sw = 0;
  bit m_btn_prev = 0;
  int m_flip_age = 0;
  bit m_flip_dir = 0;
  int rest_h[2][2] = '{'{120, 240}, '{300, 180}};
  int rest_ln[2][2] = '{'{0, 1}, '{2, 1}};

  function automatic bit m_supported(int h, bit d, logic [2:0] l);
    for (int k = 0; k < 2; k++)
      if (rest_h[d][k] == h && l[rest_ln[d][k]]) return 1;
    return 0;
  endfunction

  function automatic bit m_beyond(int h, bit d);
    return d ? (h <= 60) : (h >= 360);
  endfunction

  task automatic model_update();
    bit press;
    int nh;
    press = btn && !m_btn_prev;
    m_btn_prev = btn;
    m_sw = 0;
    if (reset) begin
      m_h = 120; m_phase = P_REST; m_btn_prev = 0; m_flip_age = 0;
      return;
    end
    case (m_phase)
      P_REST: begin
        if (press && m_supported(m_h, dir, lines)) begin
          m_sw = 1; m_phase = P_FLIP; m_flip_dir = dir; m_flip_age = 0;
        end else if (tick && !m_supported(m_h, dir, lines)) begin
          m_phase = P_MOVE;
        end
      end
      P_FLIP: begin
        if (dir != m_flip_dir) m_phase = P_MOVE;
        else begin
          m_flip_age++;
          if (m_flip_age >= 2) m_phase = P_REST;
        end
      end
      P_MOVE: begin
        if (tick) begin
          if (m_beyond(m_h, dir)) m_phase = P_DEAD;
          else begin
            nh = dir ? m_h - 4 : m_h + 4;
            m_h = nh;
            if (m_beyond(nh, dir)) m_phase = P_DEAD;
            else if (m_supported(nh, dir, lines)) m_phase = P_REST;
          end
        end
      end
      default: begin
        if (restart) begin m_h = 120; m_phase = P_REST; end
      end
    endcase
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Gravity block stand-in: flips dir one edge after the model's request, when accepting.
  task automatic step_cycle();
    bit sw_prev;
    @(posedge clk);
    sw_prev = m_sw;
    model_update();
    #1;
    if (sw_prev && accept) dir = ~dir;
  endtask

  task automatic do_tick(input int n);
    repeat (n) begin
      tick = 1; step_cycle();
      tick = 0; step_cycle();
    end
  endtask

  task automatic do_reset();
    reset = 1; step_cycle(); step_cycle(); reset = 0;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("height", {23'd0, height}, m_h);
      chk("grounded", {31'd0, grounded}, {31'd0, m_phase == P_REST});
      chk("is_dead", {31'd0, is_dead}, {31'd0, m_phase == P_DEAD});
      chk("switch_req", {31'd0, switch_req}, {31'd0, m_sw});
      if (switch_req === 1'b1) sw_seen++;
    end
  end

  initial begin
    int sw_before;
    step_cycle();
    chk_en = 1;
    step_cycle();
    reset = 0;
    chk("reset_height", {23'd0, height}, 120);
    chk("reset_grounded", {31'd0, grounded}, 1);
    chk("reset_dead", {31'd0, is_dead}, 0);
    chk("reset_sw", {31'd0, switch_req}, 0);

    // Fall from 120 up to the 240 line.
    dir = 0; lines = 3'b010;
    do_tick(31);
    chk("fall_height", {23'd0, height}, 240);
    chk("fall_grounded", {31'd0, grounded}, 1);

    // Accepted flip at 120, then walk down to the low limit.
    do_reset();
    lines = 3'b001; accept = 1;
    btn = 1; step_cycle();
    chk("flip_sw_pulse", {31'd0, switch_req}, 1);
    step_cycle();
    chk("flip_sw_single", {31'd0, switch_req}, 0);
    step_cycle();
    btn = 0; lines = 3'b000;
    do_tick(15);
    chk("death_height", {23'd0, height}, 60);
    chk("death_flag", {31'd0, is_dead}, 1);
    do_tick(2);
    chk("dead_frozen", {23'd0, height}, 60);
    restart = 1; step_cycle(); restart = 0;
    chk("restart_height", {23'd0, height}, 120);
    chk("restart_grounded", {31'd0, grounded}, 1);

    // Rejected flip: gravity block never answers.
    dir = 0; lines = 3'b001; accept = 0;
    btn = 1; step_cycle();
    chk("rej_sw", {31'd0, switch_req}, 1);
    chk("rej_in_flip", {31'd0, grounded}, 0);
    step_cycle(); step_cycle();
    chk("rej_back_rest", {31'd0, grounded}, 1);
    chk("rej_height", {23'd0, height}, 120);
    btn = 0; accept = 1; step_cycle();

    // Button edge together with a tick at 240, then hold the button through landing.
    do_reset();
    dir = 0; lines = 3'b010;
    do_tick(31);
    btn = 1; tick = 1; step_cycle(); tick = 0;
    chk("simul_sw", {31'd0, switch_req}, 1);
    chk("simul_height", {23'd0, height}, 240);
    step_cycle(); step_cycle();
    sw_before = sw_seen;
    do_tick(15);
    chk("held_land_height", {23'd0, height}, 180);
    chk("held_land_grounded", {31'd0, grounded}, 1);
    do_tick(2);
    chk("held_no_retrigger", sw_seen - sw_before, 0);
    btn = 0;

    // Reset in the middle of a move.
    dir = 0; do_reset();
    lines = 3'b000;
    do_tick(21);
    chk("mid_move_height", {23'd0, height}, 200);
    reset = 1; step_cycle(); reset = 0;
    chk("mid_move_reset", {23'd0, height}, 120);
    chk("mid_move_reset_gnd", {31'd0, grounded}, 1);

    // Randomized phase against the model.
    for (int i = 0; i < 3000; i++) begin
      tick    = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 5) == 0) btn = ~btn;
      restart = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 30) == 0) lines = 3'($urandom_range(0, 7));
      accept  = ($urandom_range(0, 3) != 0);
      reset   = ($urandom_range(0, 499) == 0);
      step_cycle();
    end
    reset = 0; tick = 0; btn = 0; restart = 0;
    step_cycle();
    @(negedge clk);
    chk_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
